// File: rtl/parking_occupancy_counter_if.sv
// Signal bundle between the entrance beam sensors / clear control and the occupancy counter.
// The counter uses the slave modport; the driving side (sensors, display) uses master.
interface parking_occupancy_counter_if;
  logic       sensor_a;
  logic       sensor_b;
  logic       clr;
  logic [7:0] bitCode;
  logic       full;
  logic       empty;
  logic       enter_pulse;
  logic       exit_pulse;
  logic       reject;
  logic       error;

  modport master (
    output sensor_a, sensor_b, clr,
    input  bitCode, full, empty, enter_pulse, exit_pulse, reject, error
  );

  modport slave (
    input  sensor_a, sensor_b, clr,
    output bitCode, full, empty, enter_pulse, exit_pulse, reject, error
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Parking-lot occupancy counter: synchronizes and debounces two entrance beams, decodes car
// direction with a sequence FSM and keeps an 8-bit count. Define PARK_TIMEOUT_EN for passage timeout.
module parking_occupancy_counter #(
  parameter int CAPACITY        = 200,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input logic                          clk,
  input logic                          rst,
  parking_occupancy_counter_if.slave   bus
);

  localparam int              DBW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]      CAP      = 8'(CAPACITY);
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IN1  = 3'd1,
    IN2  = 3'd2,
    IN3  = 3'd3,
    OUT1 = 3'd4,
    OUT2 = 3'd5,
    OUT3 = 3'd6,
    ERR  = 3'd7
  } state_t;

  // Index 1 carries sensor_a (outer), index 0 carries sensor_b (inner).
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     filt_q, filt_d;
  logic [DBW-1:0] db_cnt_q [2];
  logic [DBW-1:0] db_cnt_d [2];

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       enter_q, enter_d;
  logic       exit_q, exit_d;
  logic       reject_q, reject_d;
  logic       error_q, error_d;
  logic       enter_ev, exit_ev;

`ifdef PARK_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_passage;
`else
  logic unused_cfg;
  assign unused_cfg = ^TMO_LAST;
`endif

  // ---- Debounce: filtered level flips after DEBOUNCE_CYCLES consecutive differing samples ----
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i]   = filt_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) filt_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
  end

  // ---- Direction FSM on filtered pair {a,b} ----
  always_comb begin
    state_d  = state_q;
    enter_ev = 1'b0;
    exit_ev  = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      IDLE: case (filt_q)
              2'b10:   state_d = IN1;
              2'b01:   state_d = OUT1;
              2'b11:   state_d = ERR;
              default: state_d = IDLE;
            endcase
      IN1:  if (filt_q == 2'b11) state_d = IN2;
            else if (filt_q == 2'b00) state_d = IDLE;
      IN2:  if (filt_q == 2'b01) state_d = IN3;
            else if (filt_q == 2'b10) state_d = IN1;
      IN3:  if (filt_q == 2'b00) begin
              state_d  = IDLE;
              enter_ev = 1'b1;
            end else if (filt_q == 2'b11) state_d = IN2;
      OUT1: if (filt_q == 2'b11) state_d = OUT2;
            else if (filt_q == 2'b00) state_d = IDLE;
      OUT2: if (filt_q == 2'b10) state_d = OUT3;
            else if (filt_q == 2'b01) state_d = OUT1;
      OUT3: if (filt_q == 2'b00) begin
              state_d = IDLE;
              exit_ev = 1'b1;
            end else if (filt_q == 2'b11) state_d = OUT2;
      ERR:  if (filt_q == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef PARK_TIMEOUT_EN
    // A stalled passage overrides whatever transition the beams would have caused.
    in_passage = (state_q != IDLE) && (state_q != ERR);
    tmo_d      = in_passage ? tmo_q + TMO_W'(1) : '0;
    if (in_passage && (tmo_q == TMO_LAST)) begin
      state_d  = ERR;
      enter_ev = 1'b0;
      exit_ev  = 1'b0;
      error_d  = 1'b1;
      tmo_d    = '0;
    end
`endif
  end

  // ---- Strobes and count: strobe cycle first, count applied from the registered strobe ----
  always_comb begin
    enter_d  = enter_ev && (count_q < CAP) && !bus.clr;
    exit_d   = exit_ev && (count_q != 8'd0) && !bus.clr;
    reject_d = !bus.clr && ((enter_ev && (count_q >= CAP)) || (exit_ev && (count_q == 8'd0)));

    count_d = count_q;
    if (bus.clr)                             count_d = 8'd0;
    else if (enter_q && (count_q < CAP))     count_d = count_q + 8'd1;
    else if (exit_q && (count_q != 8'd0))    count_d = count_q - 8'd1;

    full_d  = (count_d == CAP);
    empty_d = (count_d == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= IDLE;
      count_q     <= 8'd0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      enter_q     <= 1'b0;
      exit_q      <= 1'b0;
      reject_q    <= 1'b0;
      error_q     <= 1'b0;
`ifdef PARK_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      sync1_q     <= {bus.sensor_a, bus.sensor_b};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      enter_q     <= enter_d;
      exit_q      <= exit_d;
      reject_q    <= reject_d;
      error_q     <= error_d;
`ifdef PARK_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.bitCode     = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.enter_pulse = enter_q;
  assign bus.exit_pulse  = exit_q;
  assign bus.reject      = reject_q;
`ifdef PARK_TIMEOUT_EN
  assign bus.error       = error_q;
`else
  assign bus.error       = 1'b0;
`endif

endmodule
